fetch_queue_unit: RTL
=====================

// Module: fetch_queue_unit
// PURPOSE
//  Parametrised instruction-fetch front end. Generates sequential instruction indices to the ICache over a
//  valid/ready request port, tracks in-flight reads and buffers returned words with their index in a DEPTH-entry
//  queue for decode. Accepts a redirect (base + 1 + delta), flushes the queue and discards stale in-flight responses.
//  Sits between ICache and decode; replaces the single free-running index counter.
// PARAMETERS
//  IDX_W      32  width of instruction index (word address); all index arithmetic is modulo 2^IDX_W
//  DATA_W     32  instruction word width
//  DEPTH      4   queue entries = max (outstanding + queued) words; power of 2, >= 2
//  RESET_IDX  5   first index fetched after reset
// PORTS
//  clk             in   1       clock, all state updates on rising edge
//  reset           in   1       asynchronous, active-low reset
//  redirect_valid  in   1       redirect request this cycle
//  redirect_index  in   IDX_W   index of redirecting instruction
//  redirect_delta  in   IDX_W   two's-complement offset; target = redirect_index + 1 + redirect_delta
//  ic_req_valid    out  1       fetch request valid
//  ic_req_ready    in   1       ICache accepts request
//  ic_req_index    out  IDX_W   index requested
//  ic_rsp_valid    in   1       ICache response (in order, latency >= 1, no backpressure)
//  ic_rsp_data     in   DATA_W  instruction word
//  dec_valid       out  1       queue head valid
//  dec_ready       in   1       decode consumes head
//  dec_instr       out  DATA_W  head instruction
//  dec_index       out  IDX_W   head instruction index
// BEHAVIOUR
//  Reset (reset==0, async): fetch_idx=rsp_idx=RESET_IDX, outstanding=0, drop=0, queue empty;
//   ic_req_valid=0, ic_req_index=RESET_IDX, dec_valid=0, dec_instr=0, dec_index=0. Held while reset==0.
//  Credit: ic_req_valid = !redirect_valid && (outstanding + count) < DEPTH. ic_req_index = fetch_idx.
//  Request fire (valid&&ready): fetch_idx += 1; outstanding += 1. Request data stable while valid && !ready.
//  Response: outstanding -= 1. If drop>0: word discarded, drop -= 1. Else push {ic_rsp_data, rsp_idx}; rsp_idx += 1.
//  Fire and response in same cycle: outstanding unchanged.
//  Queue: registered FIFO; word returned at cycle t visible on dec_* at t+1 (no bypass). Pop on dec_valid&&dec_ready.
//   Push and pop in same cycle legal incl. full/empty; credit rule makes overflow impossible.
//  Redirect (highest priority, one cycle): target = redirect_index + 1 + redirect_delta (mod 2^IDX_W);
//   fetch_idx<=target, rsp_idx<=target; queue flushed (dec_valid=0 next cycle); no request issued that cycle;
//   drop <= outstanding - ic_rsp_valid (response arriving that cycle is itself discarded, never enqueued).
//   A dec pop in the redirect cycle still counts as consumed. Back-to-back redirects: last one wins.
//  Throughput: with ICache latency L and dec_ready=1, one word/cycle sustained if L+1 < DEPTH.
//  Dropped responses still hold credit until they return.
//  ic_rsp_valid with outstanding==0: ignored, simulation assertion fires.
//  Wrap: indices roll over 2^IDX_W-1 -> 0 without special handling.
// TESTING
//  1 reset release, ready=1, 1-cycle ICache, dec_ready=1 -> ic_req_index 5,6,7..; dec_index 5,6,7.. one per cycle.
//  2 dec_ready=0 -> exactly DEPTH(4) requests then ic_req_valid=0; dec_ready=1 -> indices 5..8 in order, none lost.
//  3 2 outstanding, redirect_index=20 delta=3 -> next ic_req_index=24; both stale words discarded; first dec_index=24.
//  4 redirect same cycle as response with outstanding=1 -> that word discarded, drop=0, next dec_index=target.
//  5 IDX_W=4, RESET_IDX=14 -> ic_req_index 14,15,0,1; delta=-2 (4'hE) from index 3 -> target 2.
//  6 reset driven low between edges mid-stream -> outputs reset immediately; after release restart at index 5, queue empty.

Source files
------------

// File: rtl/fetch_queue_unit.sv
// Instruction-fetch front end: issues sequential ICache reads under a credit limit, buffers returned
// words with their index for decode, and handles redirects by flushing and dropping stale responses.
module fetch_queue_unit #(
    parameter int                   IDX_W     = 32,
    parameter int                   DATA_W    = 32,
    parameter int                   DEPTH     = 4,
    parameter logic [IDX_W-1:0]     RESET_IDX = IDX_W'(5)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              redirect_valid,
    input  logic [IDX_W-1:0]  redirect_index,
    input  logic [IDX_W-1:0]  redirect_delta,
    output logic              ic_req_valid,
    input  logic              ic_req_ready,
    output logic [IDX_W-1:0]  ic_req_index,
    input  logic              ic_rsp_valid,
    input  logic [DATA_W-1:0] ic_rsp_data,
    output logic              dec_valid,
    input  logic              dec_ready,
    output logic [DATA_W-1:0] dec_instr,
    output logic [IDX_W-1:0]  dec_index
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [IDX_W-1:0]  fetch_idx;
    logic [IDX_W-1:0]  rsp_idx;
    logic [CNT_W-1:0]  outstanding;
    logic [CNT_W-1:0]  count;
    logic [CNT_W-1:0]  drop;
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic [DATA_W-1:0] mem_data [DEPTH];
    logic [IDX_W-1:0]  mem_idx  [DEPTH];

    logic              credit_ok;
    logic              req_fire;
    logic              rsp_fire;
    logic              push;
    logic              pop;
    logic [IDX_W-1:0]  target;

    // Every word in flight or queued holds one credit, so the queue can never overflow.
    assign credit_ok    = ({1'b0, outstanding} + {1'b0, count}) < (CNT_W + 1)'(DEPTH);
    assign ic_req_valid = reset && !redirect_valid && credit_ok;
    assign ic_req_index = fetch_idx;
    assign req_fire     = ic_req_valid && ic_req_ready;

    assign rsp_fire = ic_rsp_valid && (outstanding != '0);
    assign push     = rsp_fire && (drop == '0) && !redirect_valid;
    assign target   = redirect_index + redirect_delta + IDX_W'(1);

    assign dec_valid = (count != '0);
    assign pop       = dec_valid && dec_ready;
    assign dec_instr = dec_valid ? mem_data[rd_ptr] : '0;
    assign dec_index = dec_valid ? mem_idx[rd_ptr]  : '0;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_idx   <= RESET_IDX;
            rsp_idx     <= RESET_IDX;
            outstanding <= '0;
            count       <= '0;
            drop        <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
        end else if (redirect_valid) begin
            // A response landing this cycle is already stale; only the rest must be dropped later.
            fetch_idx   <= target;
            rsp_idx     <= target;
            count       <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            outstanding <= outstanding - CNT_W'(rsp_fire);
            drop        <= outstanding - CNT_W'(rsp_fire);
        end else begin
            if (req_fire)
                fetch_idx <= fetch_idx + IDX_W'(1);

            if (req_fire && !rsp_fire)
                outstanding <= outstanding + CNT_W'(1);
            else if (!req_fire && rsp_fire)
                outstanding <= outstanding - CNT_W'(1);

            if (rsp_fire && (drop != '0))
                drop <= drop - CNT_W'(1);

            if (push) begin
                rsp_idx <= rsp_idx + IDX_W'(1);
                wr_ptr  <= wr_ptr + PTR_W'(1);
            end
            if (pop)
                rd_ptr <= rd_ptr + PTR_W'(1);

            if (push && !pop)
                count <= count + CNT_W'(1);
            else if (!push && pop)
                count <= count - CNT_W'(1);
        end
    end

    // NOTE: queue storage has no reset; outputs are gated by dec_valid so stale entries never show.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_data[wr_ptr] <= ic_rsp_data;
            mem_idx[wr_ptr]  <= rsp_idx;
        end
    end

    a_no_spurious_rsp: assert property (@(posedge clk) disable iff (!reset)
        !(ic_rsp_valid && (outstanding == '0)));

endmodule
